// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared definitions for the RTC bus sequencer.
//   state_t           - sequencer FSM states
//   owner_t           - which requester owns the transaction in flight
//   *_IDLE            - idle (inactive) levels of the active-low RTC strobes
//   SCAN_BASE_DEFAULT - default address of the first scanned time register
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_HOLD = 3'd2,
        ST_DATA      = 3'd3,
        ST_DATA_HOLD = 3'd4,
        ST_RECOVER   = 3'd5
    } state_t;

    typedef enum logic {
        OWN_MICRO = 1'b0,
        OWN_SCAN  = 1'b1
    } owner_t;

    localparam logic CS_IDLE = 1'b1;
    localparam logic AD_IDLE = 1'b1;
    localparam logic RD_IDLE = 1'b1;
    localparam logic WR_IDLE = 1'b1;

    localparam logic [7:0] SCAN_BASE_DEFAULT = 8'h21;

endpackage

// File: rtl/rtc_scan_scheduler.sv
// rtc_scan_scheduler: periodic refresh trigger for the RTC time registers.
// A free-running timer (mod SCAN_PERIOD) raises a pending flag on each wrap;
// while pending, scan_req asks the sequencer to read register
// SCAN_BASE + scan_idx. Each scan_done pulse advances scan_idx; after the
// last of N_SCAN registers the index wraps and pending clears.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   scan_done  - one-cycle pulse: current scan register has been read
//   scan_req   - a scan is pending
//   scan_addr  - address of the register to read next
//   scan_idx   - index of that register, 0..N_SCAN-1
module rtc_scan_scheduler
    import rtc_bus_pkg::*;
#(
    parameter int         N_SCAN      = 3,
    parameter logic [7:0] SCAN_BASE   = SCAN_BASE_DEFAULT,
    parameter int         SCAN_PERIOD = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_done,
    output logic       scan_req,
    output logic [7:0] scan_addr,
    output logic [1:0] scan_idx
);

    localparam int TW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

    logic [TW-1:0] timer;
    logic          pending;
    logic          timer_wrap;

    assign timer_wrap = (timer == TW'(SCAN_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            timer    <= '0;
            pending  <= 1'b0;
            scan_idx <= '0;
        end else begin
            timer <= timer_wrap ? '0 : timer + 1'b1;
            if (scan_done) begin
                if (scan_idx == 2'(N_SCAN - 1)) begin
                    scan_idx <= '0;
                    pending  <= 1'b0;
                end else begin
                    scan_idx <= scan_idx + 1'b1;
                end
            end
            // A wrap while already pending just leaves the flag set (never
            // queued twice). If it lands on the cycle the last register
            // finishes, the new trigger wins and a fresh scan starts at 0.
            if (timer_wrap) begin
                pending <= 1'b1;
            end
        end
    end

    assign scan_req  = pending;
    assign scan_addr = SCAN_BASE + 8'(scan_idx);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: drives the multiplexed address/data RTC bus for two
// requesters: the micro port (single reads/writes, strict priority) and the
// periodic scan engine (present only when RTC_AUTOSCAN_EN is defined).
// Each transaction walks ADDR, ADDR_HOLD, DATA, DATA_HOLD, RECOVER, every
// phase lasting T_PHASE clk cycles; all bus outputs are registered.
// Handshake: req is held high until the one-cycle req_ack pulse; req is only
// sampled in IDLE, so changes while busy are ignored, and req still high in
// the cycle after req_ack starts a new transaction.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   req, req_we           - micro request, 1=write 0=read
//   req_addr, req_wdata   - register address, write data
//   req_ack, req_rdata    - completion pulse, read result (held until next read)
//   busy                  - transaction in progress
//   scan_valid/idx/data   - one pulse per scanned register with its index/value
//   CS, AD, RD, WR        - active-low RTC strobes
//   bus_oe, bus_dout      - pad drive enable and drive value
//   bus_din               - value read back from the pad
//   dbg_state             - current FSM state (rtc_bus_pkg::state_t encoding)
// Build option: RTC_AUTOSCAN_EN enables the scan engine; without it the
// scan outputs are constant 0.
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int         T_PHASE     = 10,
    parameter int         N_SCAN      = 3,
    parameter logic [7:0] SCAN_BASE   = SCAN_BASE_DEFAULT,
    parameter int         SCAN_PERIOD = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       req_we,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       req_ack,
    output logic [7:0] req_rdata,
    output logic       busy,
    output logic       scan_valid,
    output logic [1:0] scan_idx,
    output logic [7:0] scan_data,
    output logic       CS,
    output logic       AD,
    output logic       RD,
    output logic       WR,
    output logic       bus_oe,
    output logic [7:0] bus_dout,
    input  logic [7:0] bus_din,
    output logic [2:0] dbg_state
);

    localparam int CW = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;

    if (T_PHASE < 1 || N_SCAN < 1 || N_SCAN > 4 || SCAN_PERIOD < 1 ||
        int'(SCAN_BASE) + N_SCAN > 256) begin : g_bad_params
        $error("rtc_bus_sequencer: unsupported parameter values");
    end

    state_t        state;
    owner_t        owner;
    logic [CW-1:0] cnt;
    logic          we_l;
    logic [7:0]    wdata_l;
    logic [7:0]    rdata_l;
    logic          phase_last;
    logic          enter_last_recover;
    logic          take_scan;
    logic [7:0]    start_addr;

`ifdef RTC_AUTOSCAN_EN
    logic       scan_req;
    logic [7:0] scan_addr;
    logic       scan_valid_q;
    logic [7:0] scan_data_q;

    rtc_scan_scheduler #(
        .N_SCAN      (N_SCAN),
        .SCAN_BASE   (SCAN_BASE),
        .SCAN_PERIOD (SCAN_PERIOD)
    ) u_sched (
        .clk       (clk),
        .reset     (reset),
        .scan_done (scan_valid_q),
        .scan_req  (scan_req),
        .scan_addr (scan_addr),
        .scan_idx  (scan_idx)
    );

    assign take_scan  = !req && scan_req;
    assign start_addr = req ? req_addr : scan_addr;
    assign scan_valid = scan_valid_q;
    assign scan_data  = scan_data_q;
`else
    assign take_scan  = 1'b0;
    assign start_addr = req_addr;
    assign scan_valid = 1'b0;
    assign scan_idx   = '0;
    assign scan_data  = '0;
`endif

    assign phase_last = (cnt == CW'(T_PHASE - 1));
    // Completion is reported during the last RECOVER cycle, so the registered
    // pulse is loaded on the edge that enters that cycle.
    assign enter_last_recover = (T_PHASE == 1) ? (state == ST_DATA_HOLD)
                              : (state == ST_RECOVER && cnt == CW'(T_PHASE - 2));
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= OWN_MICRO;
            cnt       <= '0;
            we_l      <= 1'b0;
            wdata_l   <= '0;
            rdata_l   <= '0;
            CS        <= CS_IDLE;
            AD        <= AD_IDLE;
            RD        <= RD_IDLE;
            WR        <= WR_IDLE;
            bus_oe    <= 1'b0;
            bus_dout  <= '0;
            req_ack   <= 1'b0;
            req_rdata <= '0;
            busy      <= 1'b0;
`ifdef RTC_AUTOSCAN_EN
            scan_valid_q <= 1'b0;
            scan_data_q  <= '0;
`endif
        end else begin
            req_ack <= 1'b0;
`ifdef RTC_AUTOSCAN_EN
            scan_valid_q <= 1'b0;
`endif
            if (state != ST_IDLE) begin
                cnt <= phase_last ? '0 : cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (req || take_scan) begin
                        owner    <= take_scan ? OWN_SCAN : OWN_MICRO;
                        we_l     <= req && req_we;
                        wdata_l  <= req_wdata;
                        state    <= ST_ADDR;
                        busy     <= 1'b1;
                        CS       <= 1'b0;
                        AD       <= 1'b0;
                        bus_oe   <= 1'b1;
                        bus_dout <= start_addr;
                    end
                end
                ST_ADDR: if (phase_last) begin
                    state <= ST_ADDR_HOLD;
                    AD    <= AD_IDLE;
                end
                ST_ADDR_HOLD: if (phase_last) begin
                    state <= ST_DATA;
                    if (we_l) begin
                        WR       <= 1'b0;
                        bus_oe   <= 1'b1;
                        bus_dout <= wdata_l;
                    end else begin
                        RD     <= 1'b0;
                        bus_oe <= 1'b0;
                    end
                end
                ST_DATA: if (phase_last) begin
                    rdata_l <= bus_din;
                    state   <= ST_DATA_HOLD;
                    RD      <= RD_IDLE;
                    WR      <= WR_IDLE;
                end
                ST_DATA_HOLD: if (phase_last) begin
                    state  <= ST_RECOVER;
                    CS     <= CS_IDLE;
                    bus_oe <= 1'b0;
                end
                ST_RECOVER: if (phase_last) begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    bus_dout <= '0;
                end
                default: state <= ST_IDLE;
            endcase

            if (enter_last_recover) begin
                if (owner == OWN_MICRO) begin
                    req_ack <= 1'b1;
                    if (!we_l) begin
                        req_rdata <= rdata_l;
                    end
                end else begin
`ifdef RTC_AUTOSCAN_EN
                    scan_valid_q <= 1'b1;
                    scan_data_q  <= rdata_l;
`endif
                end
            end
        end
    end

endmodule
